sync_down_counter: RTL and testbench
====================================

SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port ld, input, 1 bit: parallel-load strobe, active-high.
REQ-005 Port din, input, WIDTH bits: start/reload value, sampled when ld=1.
REQ-006 Port en, input, 1 bit: count enable, active-high.
REQ-007 Port mode, input, 1 bit: 0 selects one-shot, 1 selects auto-reload.
REQ-008 Port out, output, WIDTH bits: current count, registered, MSB to LSB.
REQ-009 Port tc, output, 1 bit: terminal-count pulse, registered.
REQ-010 Port busy, output, 1 bit: high while the FSM is in RUN.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and RUN; busy SHALL equal (state==RUN), with no combinational path from inputs.
REQ-012 The block SHALL hold an internal reload register (WIDTH bits), written only by ld.
REQ-013 On ld=1, whatever the state, en or mode: out<=din; reload<=din; tc<=0; next state RUN if din!=0, else IDLE.
REQ-014 ld SHALL take priority over counting in the same cycle.
REQ-015 In IDLE with ld=0: out, reload and state SHALL hold; tc<=0; en is ignored.
REQ-016 In RUN with ld=0 and en=0: out and state SHALL hold; tc<=0.
REQ-017 In RUN with ld=0, en=1 and out>1: out<=out-1; tc<=0.
REQ-018 In RUN with ld=0, en=1 and out==1: out<=0 and tc<=1, giving a single-cycle pulse coincident with out==0.
REQ-019 When the transition of REQ-018 occurs with mode=0, next state SHALL be IDLE, so busy falls in the same cycle that out becomes 0.
REQ-020 When the transition of REQ-018 occurs with mode=1, the FSM SHALL stay in RUN.
REQ-021 In RUN with ld=0, en=1, out==0 and mode=1: out<=reload; tc<=0; stay in RUN.
REQ-022 In RUN with ld=0, en=1, out==0 and mode=0 (mode changed while at zero): next state IDLE; out holds 0; tc<=0.
REQ-023 If out==0 in RUN and reload==0, the next enabled cycle SHALL move the FSM to IDLE with out=0 and tc=0; the counter SHALL NOT wrap to 2^WIDTH-1.
REQ-024 The decrement SHALL NOT underflow: out never goes from 0 to all-ones in any state or mode.
REQ-025 mode SHALL be sampled every cycle; a mid-run change takes effect at the next zero-count decision.
REQ-026 tc SHALL never be high for two consecutive cycles, and SHALL never be high without busy having been high in the previous cycle.

Reset
REQ-027 rst=0 SHALL immediately, without waiting for a clk edge, force out=0, tc=0, busy=0, reload=0 and state=IDLE.
REQ-028 While rst=0, ld and en SHALL be ignored.
REQ-029 After rst returns to 1, the block SHALL remain in IDLE until a ld.
REQ-030 Reset asserted mid-count SHALL discard the count and the reload value.

Verification
REQ-031 One-shot: reset; ld=1, din=3, mode=0 for 1 cycle; then en=1 -> out 3,2,1,0; tc=1 only in the out=0 cycle; busy 1 through out=1 and 0 from out=0; out stays 0 afterwards.
REQ-032 Auto-reload: ld din=2, mode=1, en=1 held -> out 2,1,0,2,1,0,...; tc pulses once every 3 cycles; busy stays 1.
REQ-033 Enable gating: ld din=5; en toggles 1,0,0,1 -> out 5,4,4,4,3; tc stays 0.
REQ-034 Load priority and zero load: at out=1 with en=1, ld=1 din=9 -> out=9, tc=0. ld din=0 -> out=0, busy=0, tc=0.
REQ-035 Async reset: at out=6 in RUN, drive rst low between clk edges -> out=0, busy=0, tc=0 before the next edge. Release rst, then en=1 -> no change.
REQ-036 Width check: WIDTH=8, ld din=8'hFF, mode=0, en=1 -> exactly 255 decrements to 0 with one tc pulse and no wrap to 8'hFF.

Source files
------------

// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter with one-shot / auto-reload modes.
// A two-state FSM (IDLE/RUN) gates counting and drives busy; tc is a registered one-cycle pulse.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (ld) begin
      out_d    = din;
      reload_d = din;
      state_d  = (din != ZERO) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Holds everything; en has no effect until a load.
        end
        RUN: begin
          if (en) begin
            if (out_q > ONE) begin
              out_d = out_q - ONE;
            end else if (out_q == ONE) begin
              out_d   = ZERO;
              tc_d    = 1'b1;
              state_d = mode ? RUN : IDLE;
            end else if (mode && (reload_q != ZERO)) begin
              // Sitting at zero in auto-reload: restart from the stored value.
              out_d = reload_q;
            end else begin
              // Zero with nothing to reload (or one-shot selected): park at zero, never wrap.
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      out_q    <= ZERO;
      reload_q <= ZERO;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign out  = out_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter (WIDTH=8): vector table driven through
// a scoreboard queue, plus hand sequences for async reset and the full 8-bit countdown.
module tb_sync_down_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ld = 1'b0;
  logic [W-1:0] din = '0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] out;
  logic         tc;
  logic         busy;

  sync_down_counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .din  (din),
    .en   (en),
    .mode (mode),
    .out  (out),
    .tc   (tc),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ld;
    logic [W-1:0] din;
    logic         en;
    logic         mode;
    logic [W-1:0] exp_out;
    logic         exp_tc;
    logic         exp_busy;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic         tc;
    logic         busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Watches tc for back-to-back pulses and pulses without busy in the prior cycle.
  int   tc_rule_viol = 0;
  logic tc_prev      = 1'b0;
  logic busy_prev    = 1'b0;
  always @(posedge clk) begin
    #1;
    if (tc && tc_prev) tc_rule_viol++;
    if (tc && !busy_prev) tc_rule_viol++;
    tc_prev   = tc;
    busy_prev = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.name, ".out"},  32'(out),  32'(e.out));
    check({e.name, ".tc"},   32'(tc),   32'(e.tc));
    check({e.name, ".busy"}, 32'(busy), 32'(e.busy));
  endtask

  // Drive one cycle of stimulus on the falling edge, queue its expectation,
  // then compare just after the following rising edge.
  task automatic step(input string name, input logic l, input logic [W-1:0] d,
                      input logic e, input logic m,
                      input logic [W-1:0] xo, input logic xt, input logic xb);
    exp_t x;
    @(negedge clk);
    ld = l; din = d; en = e; mode = m;
    x.name = name; x.out = xo; x.tc = xt; x.busy = xb;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    // post-reset idle, en ignored
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
    // one-shot from 3
    vecs.push_back(vec_t'{1'b1, 8'd3, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
    // auto-reload from 2, en held (ld wins over en on the load cycle)
    vecs.push_back(vec_t'{1'b1, 8'd2, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1});
    // enable gating from 5
    vecs.push_back(vec_t'{1'b1, 8'd5, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1});
    // load priority at out=1, then zero load
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 8'd9, 1'b1, 1'b0, 8'd9, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
    // mode dropped while parked at zero in RUN
    vecs.push_back(vec_t'{1'b1, 8'd1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0});
    // mode raised mid-run: takes effect at the zero decision
    vecs.push_back(vec_t'{1'b1, 8'd2, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1});

    // Reset state, asserted from time zero
    #12;
    check("reset.out", 32'(out), 32'd0);
    check("reset.tc", 32'(tc), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].ld, vecs[i].din, vecs[i].en, vecs[i].mode,
           vecs[i].exp_out, vecs[i].exp_tc, vecs[i].exp_busy);
    end

    // Async reset mid-count, between edges
    step("areset.load", 1'b1, 8'd6, 1'b0, 1'b1, 8'd6, 1'b0, 1'b1);
    @(negedge clk);
    ld = 1'b0; en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("areset.out", 32'(out), 32'd0);
    check("areset.tc", 32'(tc), 32'd0);
    check("areset.busy", 32'(busy), 32'd0);
    // ld and en ignored while reset is held
    ld = 1'b1; din = 8'd7; en = 1'b1;
    @(posedge clk);
    #1;
    check("areset.held_out", 32'(out), 32'd0);
    check("areset.held_busy", 32'(busy), 32'd0);
    @(negedge clk);
    ld = 1'b0;
    rst = 1'b1;
    step("areset.after_en0", 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    step("areset.after_en1", 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);

    // Full-width one-shot: 255 decrements, a single tc, no wrap
    step("wide.load", 1'b1, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
    for (int i = 1; i <= 255; i++) begin
      step($sformatf("wide.dec%0d", i), 1'b0, 8'd0, 1'b1, 1'b0,
           8'(255 - i), (i == 255), (i != 255));
    end
    step("wide.after0", 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    step("wide.after1", 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);

    check("tc_pulse_rule", 32'(tc_rule_viol), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
